// File: rtl/bcd_time_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_time_counter
// Purpose  : mm:ss BCD timekeeping stage with a 1 Hz prescaler and a
//            run / stop / set-minutes / set-seconds button state machine.
//            The packed BCD output feeds the seven-segment driver directly.
// Option   : define BCD_TIME_COUNTER_HOUR_EN to add the hour_wrap pulse output
// Revision : 1.0 - initial release
// ============================================================================
module bcd_time_counter #(
    parameter int TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        btn_start,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [15:0] x,
    output logic        running,
    output logic [1:0]  set_field,
`ifdef BCD_TIME_COUNTER_HOUR_EN
    output logic        hour_wrap,
`endif
    output logic        tick
);

    localparam int             CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [15:0]      time_q,  time_d;
    logic             tick_q,  tick_d;
    logic             start_q, mode_q, inc_q;
`ifdef BCD_TIME_COUNTER_HOUR_EN
    logic             wrap_q,  wrap_d;
`endif

    logic             start_p, mode_p, inc_p;
    logic [8:0]       sec_inc, min_inc;

    // Increment a two-digit BCD field modulo 60; bit 8 is the carry out.
    function automatic logic [8:0] bcd60_inc(input logic [7:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        logic       carry;
        ones  = v[3:0];
        tens  = v[7:4];
        carry = 1'b0;
        if (ones == 4'd9) begin
            ones = 4'd0;
            if (tens == 4'd5) begin
                tens  = 4'd0;
                carry = 1'b1;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            ones = ones + 4'd1;
        end
        return {carry, tens, ones};
    endfunction

    assign start_p = btn_start & ~start_q;
    assign mode_p  = btn_mode  & ~mode_q;
    assign inc_p   = btn_inc   & ~inc_q;

    assign sec_inc = bcd60_inc(time_q[7:0]);
    assign min_inc = bcd60_inc(time_q[15:8]);

    // Next-state logic: state transitions, prescaler, time advance and edits.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        time_d  = time_q;
        tick_d  = 1'b0;
`ifdef BCD_TIME_COUNTER_HOUR_EN
        wrap_d  = 1'b0;
`endif
        case (state_q)
            ST_STOPPED: begin
                // start wins over mode when both rise together
                if (start_p) begin
                    state_d = ST_RUNNING;
                end else if (mode_p) begin
                    state_d = ST_SET_MIN;
                end
            end
            ST_RUNNING: begin
                if (cnt_q == CNT_MAX) begin
                    tick_d        = 1'b1;
                    time_d[7:0]   = sec_inc[7:0];
                    if (sec_inc[8]) begin
                        time_d[15:8] = min_inc[7:0];
                    end
`ifdef BCD_TIME_COUNTER_HOUR_EN
                    wrap_d        = sec_inc[8] & min_inc[8];
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                // a stop discards the partial second; a coincident tick still lands
                if (start_p) begin
                    state_d = ST_STOPPED;
                    cnt_d   = '0;
                end
            end
            ST_SET_MIN: begin
                if (inc_p) begin
                    time_d[15:8] = min_inc[7:0];
                end
                if (mode_p) begin
                    state_d = ST_SET_SEC;
                end
            end
            ST_SET_SEC: begin
                // seconds edit wraps without touching minutes
                if (inc_p) begin
                    time_d[7:0] = sec_inc[7:0];
                end
                if (mode_p) begin
                    state_d = ST_STOPPED;
                end
            end
            default: begin
                state_d = ST_STOPPED;
            end
        endcase
    end

    // State and datapath registers; reset reloads button history from live levels.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= ST_STOPPED;
            cnt_q   <= '0;
            time_q  <= 16'h0000;
            tick_q  <= 1'b0;
            start_q <= btn_start;
            mode_q  <= btn_mode;
            inc_q   <= btn_inc;
`ifdef BCD_TIME_COUNTER_HOUR_EN
            wrap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            time_q  <= time_d;
            tick_q  <= tick_d;
            start_q <= btn_start;
            mode_q  <= btn_mode;
            inc_q   <= btn_inc;
`ifdef BCD_TIME_COUNTER_HOUR_EN
            wrap_q  <= wrap_d;
`endif
        end
    end

    // Output decode from registered state.
    always_comb begin
        set_field = 2'b00;
        case (state_q)
            ST_SET_MIN: set_field = 2'b10;
            ST_SET_SEC: set_field = 2'b01;
            default:    set_field = 2'b00;
        endcase
    end

    assign x       = time_q;
    assign tick    = tick_q;
    assign running = (state_q == ST_RUNNING);
`ifdef BCD_TIME_COUNTER_HOUR_EN
    assign hour_wrap = wrap_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_time_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_time_counter
// Purpose  : Directed self-checking bench for bcd_time_counter, TICK_DIV=4.
//            Inputs change and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_time_counter;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        btn_start;
    logic        btn_mode;
    logic        btn_inc;
    logic [15:0] x;
    logic        running;
    logic [1:0]  set_field;
    logic        tick;
`ifdef BCD_TIME_COUNTER_HOUR_EN
    logic        hour_wrap;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    bcd_time_counter #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .btn_start (btn_start),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .x         (x),
        .running   (running),
        .set_field (set_field),
`ifdef BCD_TIME_COUNTER_HOUR_EN
        .hour_wrap (hour_wrap),
`endif
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle press of the selected buttons, followed by a release cycle.
    task automatic press(input logic s, input logic m, input logic i);
        btn_start = s;
        btn_mode  = m;
        btn_inc   = i;
        @(negedge clk);
        btn_start = 1'b0;
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_n(input logic m, input logic i, input int n);
        for (int k = 0; k < n; k++) press(1'b0, m, i);
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
    endtask

    // From STOPPED, load mm:ss by counting inc presses in each set state.
    task automatic preset(input int mins, input int secs);
        press(1'b0, 1'b1, 1'b0);
        press_n(1'b0, 1'b1, mins);
        press(1'b0, 1'b1, 1'b0);
        press_n(1'b0, 1'b1, secs);
        press(1'b0, 1'b1, 1'b0);
    endtask

    // Start from STOPPED and verify the first tick lands exactly 4 clks later.
    task automatic start_and_check_tick(input string tag, input logic [15:0] exp_x);
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        check({tag, "_running"}, {31'd0, running}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check({tag, "_no_tick"}, {31'd0, tick}, 32'd0);
        end
        @(negedge clk);
        check({tag, "_tick"}, {31'd0, tick}, 32'd1);
        check({tag, "_x"}, {16'd0, x}, {16'd0, exp_x});
    endtask

    initial begin
        clr_n     = 1'b0;
        btn_start = 1'b1;
        btn_mode  = 1'b0;
        btn_inc   = 1'b0;

        // 1. reset with start held, release, then run to the first tick
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_x", {16'd0, x}, 32'h0000);
        check("rst_running_held", {31'd0, running}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
`ifdef BCD_TIME_COUNTER_HOUR_EN
        check("rst_hour_wrap", {31'd0, hour_wrap}, 32'd0);
`endif
        btn_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_running_rel", {31'd0, running}, 32'd0);
        check("rst_set_field", {30'd0, set_field}, 32'd0);
        start_and_check_tick("t1", 16'h0001);
        @(negedge clk);
        check("t1_tick_width", {31'd0, tick}, 32'd0);

        // 5. stop at prescaler=2, x frozen, restart gives a full 4-clk second
        @(negedge clk);
        press(1'b1, 1'b0, 1'b0);
        check("t5_stopped", {31'd0, running}, 32'd0);
        check("t5_frozen", {16'd0, x}, 32'h0001);
        repeat (6) @(negedge clk);
        check("t5_still_frozen", {16'd0, x}, 32'h0001);
        start_and_check_tick("t5_restart", 16'h0002);

        // 2. seconds carry into minutes from 00:58
        do_reset();
        preset(0, 58);
        check("t2_preset", {16'd0, x}, 32'h0058);
        start_and_check_tick("t2_a", 16'h0059);
        repeat (3) @(negedge clk);
        @(negedge clk);
        check("t2_carry_tick", {31'd0, tick}, 32'd1);
        check("t2_carry_x", {16'd0, x}, 32'h0100);
        press(1'b1, 1'b0, 1'b0);
        check("t2_stop", {31'd0, running}, 32'd0);

        // 2b. 59:59 wraps to 00:00
        do_reset();
        preset(59, 59);
        check("t2_preset_5959", {16'd0, x}, 32'h5959);
        start_and_check_tick("t2_wrap", 16'h0000);
`ifdef BCD_TIME_COUNTER_HOUR_EN
        check("t2_hour_wrap_hi", {31'd0, hour_wrap}, 32'd1);
        @(negedge clk);
        check("t2_hour_wrap_lo", {31'd0, hour_wrap}, 32'd0);
`endif

        // 3. minute edit wraps, seconds edit, back to STOPPED
        do_reset();
        press(1'b0, 1'b1, 1'b0);
        check("t3_set_min", {30'd0, set_field}, 32'h2);
        press_n(1'b0, 1'b1, 61);
        check("t3_min_wrap", {16'd0, x}, 32'h0100);
`ifdef BCD_TIME_COUNTER_HOUR_EN
        check("t3_no_hour_wrap", {31'd0, hour_wrap}, 32'd0);
`endif
        press(1'b0, 1'b1, 1'b0);
        check("t3_set_sec", {30'd0, set_field}, 32'h1);
        press_n(1'b0, 1'b1, 3);
        check("t3_sec_edit", {16'd0, x}, 32'h0103);
        press(1'b0, 1'b1, 1'b0);
        check("t3_back_stopped", {30'd0, set_field}, 32'h0);
        check("t3_not_running", {31'd0, running}, 32'd0);

        // 4. seconds 59 -> 00 in SET_SEC without minute carry
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press_n(1'b0, 1'b1, 56);
        check("t4_sec_59", {16'd0, x}, 32'h0159);
        press(1'b0, 1'b0, 1'b1);
        check("t4_no_carry", {16'd0, x}, 32'h0100);
        // inc and mode together: edit applied and state advances
        press(1'b0, 1'b1, 1'b1);
        check("t4_both_x", {16'd0, x}, 32'h0101);
        check("t4_both_field", {30'd0, set_field}, 32'h0);

        // 6. start+mode together in STOPPED, then reset while running
        do_reset();
        press(1'b1, 1'b1, 1'b0);
        check("t6_running", {31'd0, running}, 32'd1);
        check("t6_set_field", {30'd0, set_field}, 32'h0);
        repeat (3) @(negedge clk);
        check("t6_ticked", {16'd0, x}, 32'h0001);
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        check("t6_rst_x", {16'd0, x}, 32'h0000);
        check("t6_rst_running", {31'd0, running}, 32'd0);
        check("t6_rst_tick", {31'd0, tick}, 32'd0);
        check("t6_rst_field", {30'd0, set_field}, 32'h0);
        repeat (6) @(negedge clk);
        check("t6_idle_x", {16'd0, x}, 32'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
